// File: rtl/pti_fifo_responder.sv
// pti_fifo_responder: device side of an FT245-style 245 synchronous FIFO port.
// An RX buffer carries local bytes to the host and a TX buffer carries host bytes to the local sink.
// Defining PTI_RESP_LOOPBACK_EN routes accepted host writes straight into the RX buffer and removes the TX buffer.
module pti_fifo_responder #(
    parameter int RX_AW = 4,
    parameter int TX_AW = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic       rxf_no,
    output logic       txe_no,
    input  logic       rd_ni,
    input  logic       wr_ni,
    input  logic       oe_ni,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       dat_oe_o,
    input  logic [7:0] src_dat_i,
    input  logic       src_wr_i,
    output logic       src_full_o,
    output logic [7:0] snk_dat_o,
    output logic       snk_valid_o,
    input  logic       snk_rd_i,
    output logic [2:0] err_o
);
    localparam int RX_D = 1 << RX_AW;
    logic [7:0]       rx_mem [RX_D];
    logic [RX_AW-1:0] rx_wp, rx_rp;
    logic [RX_AW:0]   rx_cnt, rx_cnt_nxt;
    logic             rx_push, rx_pop, rx_full_q;
    logic [7:0]       rx_din;
    // RX push source and pop qualification; the host may only pop with OE asserted
    always_comb begin
        rx_pop = !rd_ni && !oe_ni && !rxf_no;
`ifdef PTI_RESP_LOOPBACK_EN
        rx_push = !wr_ni && !txe_no;
        rx_din  = dat_i;
`else
        rx_push = src_wr_i && !rx_full_q;
        rx_din  = src_dat_i;
`endif
        rx_cnt_nxt = rx_cnt + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
    end
    // RX storage is not reset; stale contents are unreachable once the pointers are cleared
    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wp] <= rx_din;
    end
    // RX pointers, count, and flags registered from the next count
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rx_wp     <= '0;
            rx_rp     <= '0;
            rx_cnt    <= '0;
            rxf_no    <= 1'b1;
            rx_full_q <= 1'b0;
        end else begin
            rx_wp     <= rx_wp + RX_AW'(rx_push);
            rx_rp     <= rx_rp + RX_AW'(rx_pop);
            rx_cnt    <= rx_cnt_nxt;
            rxf_no    <= rx_cnt_nxt == '0;
            rx_full_q <= rx_cnt_nxt == (RX_AW+1)'(RX_D);
        end
    end
`ifdef PTI_RESP_LOOPBACK_EN
    // Loopback: host write space tracks RX space and the local ports are inert
    always_comb begin
        txe_no      = rx_full_q;
        src_full_o  = 1'b1;
        snk_valid_o = 1'b0;
        snk_dat_o   = '0;
    end
`else
    localparam int TX_D = 1 << TX_AW;
    logic [7:0]       tx_mem [TX_D];
    logic [TX_AW-1:0] tx_wp, tx_rp;
    logic [TX_AW:0]   tx_cnt, tx_cnt_nxt;
    logic             tx_push, tx_pop;
    // TX push from the host and pop from the local sink
    always_comb begin
        tx_push    = !wr_ni && !txe_no;
        tx_pop     = snk_rd_i && snk_valid_o;
        tx_cnt_nxt = tx_cnt + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
        src_full_o = rx_full_q;
        snk_dat_o  = tx_mem[tx_rp];
    end
    // TX storage captures host write data
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wp] <= dat_i;
    end
    // TX pointers, count, and flags registered from the next count
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tx_wp       <= '0;
            tx_rp       <= '0;
            tx_cnt      <= '0;
            txe_no      <= 1'b0;
            snk_valid_o <= 1'b0;
        end else begin
            tx_wp       <= tx_wp + TX_AW'(tx_push);
            tx_rp       <= tx_rp + TX_AW'(tx_pop);
            tx_cnt      <= tx_cnt_nxt;
            txe_no      <= tx_cnt_nxt == (TX_AW+1)'(TX_D);
            snk_valid_o <= tx_cnt_nxt != '0;
        end
    end
`endif
    // First-word-fall-through head of RX toward the host
    always_comb dat_o = rx_mem[rx_rp];
    // Bus drive follows OE one cycle late; protocol errors are sticky until reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dat_oe_o <= 1'b0;
            err_o    <= '0;
        end else begin
            dat_oe_o <= !oe_ni;
            err_o    <= err_o | {!rd_ni && oe_ni, !wr_ni && txe_no, !rd_ni && !oe_ni && rxf_no};
        end
    end
endmodule

// File: tb/tb_pti_fifo_responder.sv
// tb_pti_fifo_responder: directed self-checking bench for pti_fifo_responder (PTI_RESP_LOOPBACK_EN selects the loopback sequence).
module tb_pti_fifo_responder;
    logic       clk_i = 1'b0;
    logic       rst_ni, rxf_no, txe_no, rd_ni, wr_ni, oe_ni, dat_oe_o;
    logic [7:0] dat_i, dat_o, src_dat_i, snk_dat_o;
    logic       src_wr_i, src_full_o, snk_valid_o, snk_rd_i;
    logic [2:0] err_o;
    int         checks = 0;
    int         failures = 0;

    pti_fifo_responder dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rxf_no(rxf_no), .txe_no(txe_no),
        .rd_ni(rd_ni), .wr_ni(wr_ni), .oe_ni(oe_ni), .dat_i(dat_i),
        .dat_o(dat_o), .dat_oe_o(dat_oe_o), .src_dat_i(src_dat_i),
        .src_wr_i(src_wr_i), .src_full_o(src_full_o), .snk_dat_o(snk_dat_o),
        .snk_valid_o(snk_valid_o), .snk_rd_i(snk_rd_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni = 1'b0; rd_ni = 1'b1; wr_ni = 1'b0; oe_ni = 1'b1; dat_i = 8'h00;
        src_dat_i = 8'h00; src_wr_i = 1'b0; snk_rd_i = 1'b0;
        step();
        step();
        wr_ni = 1'b1;
        chk("rst_rxf", {7'd0, rxf_no}, 8'h01);
        chk("rst_txe", {7'd0, txe_no}, 8'h00);
        chk("rst_oe", {7'd0, dat_oe_o}, 8'h00);
        chk("rst_err", {5'd0, err_o}, 8'h00);
        rst_ni = 1'b1;
`ifdef PTI_RESP_LOOPBACK_EN
        chk("lb_src_full", {7'd0, src_full_o}, 8'h01);
        chk("lb_snk_valid", {7'd0, snk_valid_o}, 8'h00);
        wr_ni = 1'b0; dat_i = 8'h5A;
        step();
        wr_ni = 1'b1;
        chk("lb_rxf", {7'd0, rxf_no}, 8'h00);
        chk("lb_dat", dat_o, 8'h5A);
        oe_ni = 1'b0;
        step();
        rd_ni = 1'b0;
        step();
        rd_ni = 1'b1; oe_ni = 1'b1;
        chk("lb_rxf_empty", {7'd0, rxf_no}, 8'h01);
        chk("lb_txe", {7'd0, txe_no}, 8'h00);
        chk("lb_err", {5'd0, err_o}, 8'h00);
`else
        chk("rst_src_full", {7'd0, src_full_o}, 8'h00);
        chk("rst_snk_valid", {7'd0, snk_valid_o}, 8'h00);
        src_wr_i = 1'b1; src_dat_i = 8'h11;
        step();
        src_dat_i = 8'h22;
        step();
        src_dat_i = 8'h33;
        step();
        src_wr_i = 1'b0;
        chk("rd_rxf_low", {7'd0, rxf_no}, 8'h00);
        oe_ni = 1'b0;
        step();
        chk("rd_oe", {7'd0, dat_oe_o}, 8'h01);
        rd_ni = 1'b0;
        chk("rd_b0", dat_o, 8'h11);
        step();
        chk("rd_b1", dat_o, 8'h22);
        step();
        chk("rd_b2", dat_o, 8'h33);
        chk("rd_rxf_before", {7'd0, rxf_no}, 8'h00);
        step();
        rd_ni = 1'b1;
        chk("rd_rxf_empty", {7'd0, rxf_no}, 8'h01);
        chk("rd_err", {5'd0, err_o}, 8'h00);
        oe_ni = 1'b1;
        step();
        chk("rd_oe_off", {7'd0, dat_oe_o}, 8'h00);
        wr_ni = 1'b0;
        for (int i = 0; i < 17; i++) begin
            dat_i = 8'(i);
            step();
            if (i == 0) chk("wr_snk_valid", {7'd0, snk_valid_o}, 8'h01);
            if (i == 14) chk("wr_txe_15", {7'd0, txe_no}, 8'h00);
            if (i == 15) chk("wr_txe_full", {7'd0, txe_no}, 8'h01);
        end
        wr_ni = 1'b1;
        chk("wr_err", {5'd0, err_o}, 8'h02);
        snk_rd_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("snk_%0d", i), snk_dat_o, 8'(i));
            step();
        end
        snk_rd_i = 1'b0;
        chk("snk_empty", {7'd0, snk_valid_o}, 8'h00);
        chk("snk_txe", {7'd0, txe_no}, 8'h00);
        src_wr_i = 1'b1; src_dat_i = 8'hA5;
        step();
        src_wr_i = 1'b0; rd_ni = 1'b0;
        step();
        rd_ni = 1'b1;
        chk("nooe_dat", dat_o, 8'hA5);
        chk("nooe_rxf", {7'd0, rxf_no}, 8'h00);
        chk("nooe_err", {5'd0, err_o}, 8'h06);
        src_wr_i = 1'b1; src_dat_i = 8'hC3; oe_ni = 1'b0; rd_ni = 1'b0;
        step();
        src_wr_i = 1'b0; rd_ni = 1'b1;
        chk("same_rxf", {7'd0, rxf_no}, 8'h00);
        chk("same_dat", dat_o, 8'hC3);
        rd_ni = 1'b0;
        step();
        rd_ni = 1'b1; oe_ni = 1'b1;
        chk("same_cnt1", {7'd0, rxf_no}, 8'h01);
        chk("same_err", {5'd0, err_o}, 8'h06);
        src_wr_i = 1'b1; src_dat_i = 8'h77;
        step();
        src_wr_i = 1'b0; rst_ni = 1'b0; wr_ni = 1'b0; rd_ni = 1'b0;
        step();
        rst_ni = 1'b1; wr_ni = 1'b1; rd_ni = 1'b1;
        chk("mid_rst_rxf", {7'd0, rxf_no}, 8'h01);
        chk("mid_rst_err", {5'd0, err_o}, 8'h00);
        chk("mid_rst_snk", {7'd0, snk_valid_o}, 8'h00);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
